icache_fetch: RTL and testbench

//   Direct-mapped, read-only instruction cache that supplies the fetch stage of the pipelined core.

---
 rtl/icache_fetch.sv | 188 ++++++++++++++++++
 tb/tb_icache_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// ---------------------------------------------------------------------------
// icache_fetch
//   Direct-mapped, read-only instruction cache between the core's fetch stage
//   and the instruction memory port. A one-cycle instrreq pulse is looked up
//   combinationally. A hit returns the instruction in the same cycle. A miss
//   raises abort and refills the whole line from memory, one word per beat,
//   using a memreq/memready handshake. It then presents the requested word
//   for one RESPOND cycle.
//
//   Address layout (byte address):
//     [1:0]                byte within word (ignored)
//     [OB+1:2]             word offset within line
//     [OB+IB+1:OB+2]       line index
//     [AW-1:OB+IB+2]       tag
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   instrreq  in   fetch request pulse from the core
//   instradr  in   byte address of the instruction
//   instrF    out  fetched instruction (holds when idle)
//   hit       out  request served from the cache this cycle
//   abort     out  instruction not available yet; core must wait
//   memreq    out  refill beat request to instruction memory
//   memadr    out  word-aligned byte address of the current refill beat
//   memrdata  in   refill data, valid with memready
//   memready  in   beat accepted / memrdata valid
// ---------------------------------------------------------------------------
module icache_fetch #(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instrreq,
    input  logic [AW-1:0] instradr,
    output logic [31:0]   instrF,
    output logic          hit,
    output logic          abort,
    output logic          memreq,
    output logic [AW-1:0] memadr,
    input  logic [31:0]   memrdata,
    input  logic          memready
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = AW - IB - OB - 2;
    localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t            state;

    // Line storage. Data and tags need no reset; valid bits gate every use.
    logic [31:0]       data_mem [LINES][WORDS];
    logic [TW-1:0]     tag_mem  [LINES];
    logic [LINES-1:0]  valid;

    logic [OB-1:0]     cnt;       // refill beat counter
    logic [AW-1:0]     reqadr;    // address of the missing request
    logic [31:0]       instr_q;   // last presented instruction

    // Lookup fields from the live request address.
    logic [OB-1:0]     lk_off;
    logic [IB-1:0]     lk_idx;
    logic [TW-1:0]     lk_tag;

    // Fields of the latched miss address; the refill always targets these.
    logic [OB-1:0]     rq_off;
    logic [IB-1:0]     rq_idx;
    logic [TW-1:0]     rq_tag;

    logic              lookup_hit;
    logic              req_idle;
    logic              fill_beat;
    logic              unused_bits;

    assign lk_off = instradr[OB+1:2];
    assign lk_idx = instradr[OB+IB+1:OB+2];
    assign lk_tag = instradr[AW-1:OB+IB+2];

    assign rq_off = reqadr[OB+1:2];
    assign rq_idx = reqadr[OB+IB+1:OB+2];
    assign rq_tag = reqadr[AW-1:OB+IB+2];

    // Byte-select bits play no part in an instruction fetch.
    assign unused_bits = ^{instradr[1:0], reqadr[1:0]};

    assign lookup_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

    // Requests are only looked up in IDLE. Requests in REFILL or RESPOND are
    // ignored. Reset masks the lookup so that abort drops at once.
    assign req_idle  = (state == IDLE) && instrreq && !reset;
    assign fill_beat = (state == REFILL) && memready;

    // Response path: hit and abort are combinational so that a hit is
    // answered in the request cycle.
    always_comb begin
        hit    = 1'b0;
        abort  = 1'b0;
        instrF = instr_q;
        if (req_idle) begin
            if (lookup_hit) begin
                hit    = 1'b1;
                instrF = data_mem[lk_idx][lk_off];
            end else begin
                abort  = 1'b1;
            end
        end else if (state == REFILL) begin
            abort  = 1'b1;
        end else if (state == RESPOND) begin
            // The last beat was written on the edge entering RESPOND.
            instrF = data_mem[rq_idx][rq_off];
        end
    end

    // Line data and tag writes happen only during refill beats.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[rq_idx][cnt] <= memrdata;
            if (cnt == LAST_BEAT) begin
                tag_mem[rq_idx] <= rq_tag;
            end
        end
    end

    // Control FSM with registered memory-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            valid   <= '0;
            cnt     <= '0;
            reqadr  <= '0;
            memreq  <= 1'b0;
            memadr  <= '0;
            instr_q <= '0;
        end else begin
            // instrF holds its value whenever nothing new is presented.
            instr_q <= instrF;
            case (state)
                IDLE: begin
                    if (instrreq && !lookup_hit) begin
                        reqadr        <= instradr;
                        // The line is invalidated now, so a reset in the
                        // middle of the refill leaves it invalid.
                        valid[lk_idx] <= 1'b0;
                        cnt           <= '0;
                        memreq        <= 1'b1;
                        memadr        <= {instradr[AW-1:OB+2], {OB{1'b0}}, 2'b00};
                        state         <= REFILL;
                    end
                end

                REFILL: begin
                    // With memready low, memreq and memadr simply hold.
                    if (memready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            valid[rq_idx] <= 1'b1;
                            memreq        <= 1'b0;
                            memadr        <= '0;
                            state         <= RESPOND;
                        end else begin
                            // Only the offset field advances, so the refill
                            // stays inside the line.
                            memadr[OB+1:2] <= cnt + 1'b1;
                        end
                    end
                end

                RESPOND: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// ---------------------------------------------------------------------------
// tb_icache_fetch
//   Directed bench for icache_fetch (LINES=16, WORDS=4, AW=32). The memory
//   model returns word = address ^ 32'hA5A5_0000 with no delay.
// ---------------------------------------------------------------------------
module tb_icache_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        instrreq;
    logic [31:0] instradr;
    logic [31:0] instrF;
    logic        hit;
    logic        abort;
    logic        memreq;
    logic [31:0] memadr;
    logic [31:0] memrdata;
    logic        memready;

    int total;
    int bad;

    icache_fetch #(
        .LINES (16),
        .WORDS (4),
        .AW    (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .instrreq (instrreq),
        .instradr (instradr),
        .instrF   (instrF),
        .hit      (hit),
        .abort    (abort),
        .memreq   (memreq),
        .memadr   (memadr),
        .memrdata (memrdata),
        .memready (memready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memrdata = memadr ^ KEY;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Full miss: request cycle, WORDS beats with an optional stall run, the
    // RESPOND cycle, and one idle cycle after it.
    task automatic do_miss(input logic [31:0] addr, input int stall_at, input int stall_n);
        logic [31:0] base;
        logic [31:0] expw;
        base = {addr[31:4], 4'h0};
        expw = addr ^ KEY;

        @(negedge clk);
        instrreq = 1'b1;
        instradr = addr;
        memready = 1'b0;
        #1;
        chk("miss_abort", {31'd0, abort}, 32'd1);
        chk("miss_hit", {31'd0, hit}, 32'd0);
        chk("miss_memreq_idle", {31'd0, memreq}, 32'd0);

        for (int b = 0; b < 4; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    // A request during a refill is ignored.
                    instrreq = 1'b1;
                    instradr = 32'h0040_0000;
                    memready = 1'b0;
                    #1;
                    chk("stall_memreq", {31'd0, memreq}, 32'd1);
                    chk("stall_memadr", memadr, base + 32'(4 * b));
                    chk("stall_abort", {31'd0, abort}, 32'd1);
                    chk("stall_hit", {31'd0, hit}, 32'd0);
                end
            end
            @(negedge clk);
            instrreq = 1'b0;
            memready = 1'b1;
            #1;
            chk("beat_memreq", {31'd0, memreq}, 32'd1);
            chk("beat_memadr", memadr, base + 32'(4 * b));
            chk("beat_abort", {31'd0, abort}, 32'd1);
        end

        @(negedge clk);
        memready = 1'b0;
        #1;
        chk("rsp_abort", {31'd0, abort}, 32'd0);
        chk("rsp_hit", {31'd0, hit}, 32'd0);
        chk("rsp_memreq", {31'd0, memreq}, 32'd0);
        chk("rsp_instr", instrF, expw);

        @(negedge clk);
        #1;
        chk("post_instr_hold", instrF, expw);
        chk("post_abort", {31'd0, abort}, 32'd0);
        chk("post_memreq", {31'd0, memreq}, 32'd0);
    endtask

    // One request cycle that must hit; instrreq is left high for the caller.
    task automatic do_hit(input logic [31:0] addr);
        @(negedge clk);
        instrreq = 1'b1;
        instradr = addr;
        memready = 1'b0;
        #1;
        chk("hit_hit", {31'd0, hit}, 32'd1);
        chk("hit_abort", {31'd0, abort}, 32'd0);
        chk("hit_memreq", {31'd0, memreq}, 32'd0);
        chk("hit_instr", instrF, addr ^ KEY);
    endtask

    initial begin
        logic [31:0] a;
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        instrreq = 1'b0;
        instradr = 32'h0;
        memready = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_instr", instrF, 32'h0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_abort", {31'd0, abort}, 32'd0);
        chk("rst_memreq", {31'd0, memreq}, 32'd0);
        chk("rst_memadr", memadr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Cold miss, then a hit on the same line
        do_miss(32'h0040_0008, -1, 0);
        do_hit(32'h0040_000C);
        @(negedge clk);
        instrreq = 1'b0;
        #1;
        chk("idle_hold_instr", instrF, 32'hA5E5_000C);
        chk("idle_hit", {31'd0, hit}, 32'd0);
        chk("idle_memreq", {31'd0, memreq}, 32'd0);

        // Conflict on index 0 evicts the first line
        do_miss(32'h0040_0100, -1, 0);
        do_hit(32'h0040_0104);
        do_miss(32'h0040_0000, -1, 0);

        // Three wait cycles before the second beat
        do_miss(32'h0080_0004, 1, 3);
        do_hit(32'h0080_000C);

        // Reset after two beats of a refill
        @(negedge clk);
        instrreq = 1'b1;
        instradr = 32'h0040_0030;
        #1;
        chk("rr_miss_abort", {31'd0, abort}, 32'd1);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            instrreq = 1'b0;
            memready = 1'b1;
            #1;
            chk("rr_beat_memadr", memadr, 32'h0040_0030 + 32'(4 * b));
        end
        @(negedge clk);
        memready = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rr_memreq", {31'd0, memreq}, 32'd0);
        chk("rr_abort", {31'd0, abort}, 32'd0);
        chk("rr_instr", instrF, 32'h0);
        chk("rr_memadr", memadr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        do_miss(32'h0040_0034, -1, 0);

        // Warm all 16 lines, then hit each one back-to-back
        for (int i = 0; i < 16; i++) begin
            a = 32'h0010_0000 | (32'(i) << 4) | (32'(i & 3) << 2);
            do_miss(a, -1, 0);
        end
        for (int i = 0; i < 16; i++) begin
            a = 32'h0010_0000 | (32'(i) << 4) | (32'(3 - (i & 3)) << 2);
            do_hit(a);
        end
        @(negedge clk);
        instrreq = 1'b0;
        #1;
        chk("end_memreq", {31'd0, memreq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
